mdy_shift_reg_p: RTL and testbench

- Parametrised W*N_WORDS-bit operand register for the modular-division datapath; next generation of the fixed 16x16 right-shift/set register.
- Word-serial load, word rotate, multi-bit right/left shift with serial fill, set-to-one and clear, all issued through a valid/ready command port.
- Adds a done pulse and zero/one flags that the division controller consumes.

---
 rtl/mdy_shift_reg_p_pkg.sv | 27 ++
 rtl/mdy_shift_reg_p_if.sv | 30 +++
 rtl/mdy_shift_reg_p_ctl.sv | 75 +++++++
 rtl/mdy_shift_reg_p.sv | 80 ++++++++
 tb/tb_mdy_shift_reg_p.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdy_shift_reg_p_pkg.sv
// Shared definitions for the modular-division operand register: command
// op-codes, controller states and op-class helpers.
package mdy_shift_reg_p_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LDW  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_SHL  = 3'd3;
   localparam logic [2:0] OP_SET1 = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_ROTW = 3'd6;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Ops that complete in the accept cycle regardless of operands.
   function automatic logic is_single(input logic [2:0] op);
      return (op == OP_LDW) || (op == OP_ROTW) || (op == OP_SET1) || (op == OP_CLR);
   endfunction

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SHR) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/mdy_shift_reg_p_if.sv
// Command port and status bundle of the operand register; the controller
// side is the master, the register is the slave.
interface mdy_shift_reg_p_if #(
   parameter int W     = 16,
   parameter int CNT_W = 9
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [W-1:0]     word_in;
   logic             ser_in;
   logic [W-1:0]     word_out;
   logic             lsb_out;
   logic             msb_out;
   logic             busy;
   logic             done;
   logic             is_zero;
   logic             is_one;

   modport master (
      output cmd_valid, cmd_op, cmd_cnt, word_in, ser_in,
      input  cmd_ready, word_out, lsb_out, msb_out, busy, done, is_zero, is_one
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_cnt, word_in, ser_in,
      output cmd_ready, word_out, lsb_out, msb_out, busy, done, is_zero, is_one
   );
endinterface

// File: rtl/mdy_shift_reg_p_ctl.sv
// Command sequencer: accepts commands, runs the shift down-counter and
// produces busy/done/ready plus the per-edge shift enable and direction.
module mdy_shift_reg_p_ctl
   import mdy_shift_reg_p_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             cmd_ready,
   output logic             busy,
   output logic             done,
   output logic             shift_en,
   output logic             shift_left
);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             left_reg;
   logic             accept;

   assign accept = cmd_valid && !busy_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         left_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (is_single(cmd_op)) begin
                     done_reg <= 1'b1;
                  end else if (is_shift(cmd_op)) begin
                     // A zero-distance shift completes like a single-cycle op.
                     if (cmd_cnt == '0) begin
                        done_reg <= 1'b1;
                     end else begin
                        state_reg <= SHIFT;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= cmd_cnt;
                        left_reg  <= (cmd_op == OP_SHL);
                     end
                  end
               end
            end
            SHIFT: begin
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = !busy_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign shift_en   = (state_reg == SHIFT);
   assign shift_left = left_reg;

endmodule

// File: rtl/mdy_shift_reg_p.sv
// W*N_WORDS-bit operand register with word-serial load, word rotate and
// multi-bit serial-fill shifts driven through a valid/ready command port.
module mdy_shift_reg_p
   import mdy_shift_reg_p_pkg::*;
#(
   parameter int W       = 16,
   parameter int N_WORDS = 16,
   parameter int CNT_W   = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   mdy_shift_reg_p_if.slave  bus
);

   localparam int TOT = W * N_WORDS;

   logic [TOT-1:0] r_reg;
   logic [TOT-1:0] r_next;
   logic           cmd_ready;
   logic           busy;
   logic           done;
   logic           shift_en;
   logic           shift_left;
   logic           accept;

   mdy_shift_reg_p_ctl #(
      .CNT_W (CNT_W)
   ) u_ctl (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (bus.cmd_valid),
      .cmd_op     (bus.cmd_op),
      .cmd_cnt    (bus.cmd_cnt),
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .done       (done),
      .shift_en   (shift_en),
      .shift_left (shift_left)
   );

   assign accept = bus.cmd_valid && cmd_ready;

   // A running shift owns the register; new commands only land while idle.
   always_comb begin
      r_next = r_reg;
      if (shift_en) begin
         if (shift_left) begin
            r_next = {r_reg[TOT-2:0], bus.ser_in};
         end else begin
            r_next = {bus.ser_in, r_reg[TOT-1:1]};
         end
      end else if (accept) begin
         case (bus.cmd_op)
            OP_LDW:  r_next = {bus.word_in, r_reg[TOT-1:W]};
            OP_ROTW: r_next = {r_reg[W-1:0], r_reg[TOT-1:W]};
            OP_SET1: r_next = TOT'(1);
            OP_CLR:  r_next = '0;
            default: r_next = r_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg <= '0;
      end else begin
         r_reg <= r_next;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.word_out  = r_reg[W-1:0];
   assign bus.lsb_out   = r_reg[0];
   assign bus.msb_out   = r_reg[TOT-1];
   assign bus.is_zero   = (r_reg == '0);
   assign bus.is_one    = (r_reg == TOT'(1));

endmodule

// File: tb/tb_mdy_shift_reg_p.sv
// Scoreboard bench for mdy_shift_reg_p: the driver predicts each command's
// result with whole-vector arithmetic, the monitor checks it on every done.
module tb_mdy_shift_reg_p;
   import mdy_shift_reg_p_pkg::*;

   localparam int W       = 16;
   localparam int N_WORDS = 16;
   localparam int CNT_W   = 9;
   localparam int TOT     = W * N_WORDS;

   typedef struct {
      logic [TOT-1:0] r;
      int             edge_no;
      int             busy_cycles;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mdy_shift_reg_p_if #(.W(W), .CNT_W(CNT_W)) bus ();

   mdy_shift_reg_p #(.W(W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t           sb[$];
   exp_t           mon_e;
   logic [TOT-1:0] model;
   int             edge_cnt = 0;
   int             busy_run = 0;
   int             n_checks = 0;
   int             n_pass   = 0;

   always @(posedge clk) edge_cnt++;

   task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Monitor: every done pulse retires exactly one predicted response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.busy) busy_run++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", {{(TOT-1){1'b0}}, bus.done}, '0);
            end else begin
               mon_e = sb.pop_front();
               chk("word_out", {{(TOT-W){1'b0}}, bus.word_out}, {{(TOT-W){1'b0}}, mon_e.r[W-1:0]});
               chk("flags lsb/msb/zero/one",
                   {{(TOT-4){1'b0}}, bus.lsb_out, bus.msb_out, bus.is_zero, bus.is_one},
                   {{(TOT-4){1'b0}}, mon_e.r[0], mon_e.r[TOT-1], (mon_e.r == '0), (mon_e.r == TOT'(1))});
               chk("done_edge", TOT'(edge_cnt), TOT'(mon_e.edge_no));
               chk("busy_cycles", TOT'(busy_run), TOT'(mon_e.busy_cycles));
            end
            busy_run = 0;
         end
      end
   end

   task automatic push(input int edge_no, input int bc);
      exp_t e;
      e.r = model;
      e.edge_no = edge_no;
      e.busy_cycles = bc;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [2:0] op, input int k, input logic [W-1:0] w, input logic s,
                        output int acc_edge);
      int             guard;
      logic           rdy;
      logic           accepted;
      logic [TOT-1:0] ones;
      ones = '1;
      acc_edge = -1;
      @(negedge clk);
      if (op == OP_SHR || op == OP_SHL) begin
         guard = 0;
         while (!bus.cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         bus.ser_in = s;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_cnt   = CNT_W'(k);
      bus.word_in   = w;
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 2000) begin
         rdy = bus.cmd_ready;
         @(posedge clk);
         if (rdy) accepted = 1'b1;
         else begin
            guard++;
            @(negedge clk);
         end
      end
      #1;
      bus.cmd_valid = 1'b0;
      if (!accepted) begin
         chk("accept_timeout", {{(TOT-1){1'b0}}, accepted}, TOT'(1));
      end else begin
         acc_edge = edge_cnt;
         case (op)
            OP_LDW:  begin model = (model >> W) | (TOT'(w) << (TOT - W)); push(edge_cnt, 0); end
            OP_ROTW: begin model = (model >> W) | (model << (TOT - W)); push(edge_cnt, 0); end
            OP_SET1: begin model = TOT'(1); push(edge_cnt, 0); end
            OP_CLR:  begin model = '0; push(edge_cnt, 0); end
            OP_SHR:  begin
               model = (model >> k) | (s ? ~(ones >> k) : '0);
               push(edge_cnt + k, k);
            end
            OP_SHL:  begin
               model = (model << k) | (s ? ~(ones << k) : '0);
               push(edge_cnt + k, k);
            end
            default: ;
         endcase
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) chk("drain_timeout", TOT'(sb.size()), '0);
      @(negedge clk);
   endtask

   initial begin
      int ae;
      int ae2;
      int k;
      logic [2:0] op;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_cnt   = '0;
      bus.word_in   = '0;
      bus.ser_in    = 1'b0;
      model         = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset zero/busy/done/ready",
          {{(TOT-4){1'b0}}, bus.is_zero, bus.busy, bus.done, bus.cmd_ready}, TOT'(4'b1001));
      chk("reset word_out", TOT'(bus.word_out), '0);

      // Word-serial load of 1..16, then rotate once round to see every word.
      for (int i = 1; i <= N_WORDS; i++) issue(OP_LDW, 0, W'(i), 1'b0, ae);
      wait_idle();
      chk("t1 lsw", TOT'(bus.word_out), TOT'(16'h0001));
      for (int i = 0; i < N_WORDS; i++) issue(OP_ROTW, 0, '0, 1'b0, ae);
      wait_idle();
      chk("t6 rotw restore", TOT'(bus.word_out), TOT'(16'h0001));

      issue(OP_SET1, 0, '0, 1'b0, ae);
      @(negedge clk);
      chk("t2 set1 is_one", TOT'(bus.is_one), TOT'(1));
      issue(OP_CLR, 0, '0, 1'b0, ae);
      @(negedge clk);
      chk("t2 clr zero/one", TOT'({bus.is_zero, bus.is_one}), TOT'(2'b10));

      issue(OP_SET1, 0, '0, 1'b0, ae);
      issue(OP_SHR, 4, '0, 1'b1, ae);
      wait_idle();
      chk("t3 msb/lsb", TOT'({bus.msb_out, bus.lsb_out}), TOT'(2'b10));

      for (int i = 0; i < N_WORDS; i++) issue(OP_LDW, 0, 16'hFFFF, 1'b0, ae);
      issue(OP_SHL, 256, '0, 1'b0, ae);
      wait_idle();
      chk("t4 shl256 zero", TOT'(bus.is_zero), TOT'(1));
      issue(OP_SET1, 0, '0, 1'b0, ae);
      issue(OP_SHR, 0, '0, 1'b1, ae);
      wait_idle();
      chk("t4 shr0 unchanged", TOT'(bus.is_one), TOT'(1));

      // CLR held against a running shift must wait for it to finish.
      issue(OP_SHR, 10, '0, 1'b1, ae);
      issue(OP_CLR, 0, '0, 1'b1, ae2);
      chk("t5 clr accept edge", TOT'(ae2), TOT'(ae + 11));
      wait_idle();
      chk("t5 clr zero", TOT'(bus.is_zero), TOT'(1));

      // Reset in the middle of a shift abandons it without a done pulse.
      issue(OP_SET1, 0, '0, 1'b0, ae);
      issue(OP_SHR, 10, '0, 1'b1, ae);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      model = '0;
      busy_run = 0;
      #1;
      chk("t6 rst zero/busy/done",
          TOT'({bus.is_zero, bus.busy, bus.done}), TOT'(3'b100));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("t6 post-rst ready/busy/zero",
          TOT'({bus.cmd_ready, bus.busy, bus.is_zero}), TOT'(3'b101));

      for (int n = 0; n < 80; n++) begin
         op = 3'($urandom_range(0, 7));
         k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 511)) : int'($urandom_range(0, 12));
         issue(op, k, W'($urandom), 1'($urandom), ae);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      chk("final queue empty", TOT'(sb.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
